// File: rtl/irrigation_actuator.sv
// Irrigation valve/pump sequencer: timed sprinkler, drip and sprinkler-drip runs with wet-soil abort and fault latch.
// Optional pump pre-start phase is enabled by defining IRRIG_PUMP_PRESTART_EN.
module irrigation_actuator #(
    parameter int SPRINKLE_TICKS    = 60,
    parameter int DRIP_TICKS        = 120,
    parameter int SD_SPRINKLE_TICKS = 45,
    parameter int PRIME_TICKS       = 2
) (
    input  logic       clk,
    input  logic       init,
    input  logic [2:0] type_of_irrigation_state,
    input  logic       water_ok,
    input  logic       tick,
    output logic       sprinkler_valve,
    output logic       drip_valve,
    output logic       pump,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE,
`ifdef IRRIG_PUMP_PRESTART_EN
        PRIME,
`endif
        SPRINKLE,
        SD_SPRINKLE,
        SD_DRIP,
        DRIP,
        DONE,
        FAULT
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] lim;
    logic       cmd_valid;
    logic       last_tick;
    state_t     run_state;

`ifdef IRRIG_PUMP_PRESTART_EN
    logic [2:0] run_sel, run_sel_nxt;
`endif

    // Only the three one-hot codes are legal commands.
    assign cmd_valid = (type_of_irrigation_state == 3'b100) ||
                       (type_of_irrigation_state == 3'b010) ||
                       (type_of_irrigation_state == 3'b001);

    function automatic state_t first_run(input logic [2:0] cmd);
        state_t s;
        case (cmd)
            3'b100:  s = SPRINKLE;
            3'b010:  s = DRIP;
            default: s = SD_SPRINKLE;
        endcase
        return s;
    endfunction

    always_comb begin
        lim = 8'(PRIME_TICKS);
        case (state)
            SPRINKLE:    lim = 8'(SPRINKLE_TICKS);
            SD_SPRINKLE: lim = 8'(SD_SPRINKLE_TICKS);
            SD_DRIP:     lim = 8'(DRIP_TICKS);
            DRIP:        lim = 8'(DRIP_TICKS);
            default:     lim = 8'(PRIME_TICKS);
        endcase
    end

    assign last_tick = tick && (cnt == lim - 8'd1);

`ifdef IRRIG_PUMP_PRESTART_EN
    assign run_state = first_run(run_sel);
`else
    assign run_state = first_run(type_of_irrigation_state);
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
`ifdef IRRIG_PUMP_PRESTART_EN
        run_sel_nxt = run_sel;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = 8'd0;
                if (type_of_irrigation_state != 3'b000) begin
                    if (!cmd_valid || !water_ok) begin
                        state_nxt = FAULT;
                    end else begin
`ifdef IRRIG_PUMP_PRESTART_EN
                        run_sel_nxt = type_of_irrigation_state;
                        state_nxt   = PRIME;
`else
                        state_nxt   = run_state;
`endif
                    end
                end
            end
            DONE: begin
                cnt_nxt = 8'd0;
                if (type_of_irrigation_state == 3'b000)
                    state_nxt = IDLE;
            end
            FAULT: begin
                cnt_nxt = 8'd0;
                if (type_of_irrigation_state == 3'b000 && water_ok)
                    state_nxt = IDLE;
            end
            default: begin
                // Aborts win over a coincident tick; reservoir loss wins over wet soil.
                if (!water_ok) begin
                    state_nxt = FAULT;
                    cnt_nxt   = 8'd0;
                end else if (type_of_irrigation_state == 3'b000) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else if (last_tick) begin
                    cnt_nxt = 8'd0;
                    case (state)
                        SD_SPRINKLE: state_nxt = SD_DRIP;
`ifdef IRRIG_PUMP_PRESTART_EN
                        PRIME:       state_nxt = run_state;
`endif
                        default:     state_nxt = DONE;
                    endcase
                end else if (tick) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!init) begin
            state           <= IDLE;
            cnt             <= 8'd0;
            sprinkler_valve <= 1'b0;
            drip_valve      <= 1'b0;
            pump            <= 1'b0;
            busy            <= 1'b0;
            fault           <= 1'b0;
`ifdef IRRIG_PUMP_PRESTART_EN
            run_sel         <= 3'b000;
`endif
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            // Outputs decode the state being entered so they change on the entry edge.
            sprinkler_valve <= (state_nxt == SPRINKLE) || (state_nxt == SD_SPRINKLE);
            drip_valve      <= (state_nxt == DRIP) || (state_nxt == SD_DRIP);
            pump            <= !((state_nxt == IDLE) || (state_nxt == DONE) || (state_nxt == FAULT));
            busy            <= !((state_nxt == IDLE) || (state_nxt == DONE) || (state_nxt == FAULT));
            fault           <= (state_nxt == FAULT);
`ifdef IRRIG_PUMP_PRESTART_EN
            run_sel         <= run_sel_nxt;
`endif
        end
    end

endmodule

// File: doc/irrigation_actuator.md
IRRIGATION_ACTUATOR -- requirements
Module: irrigation_actuator

Interface
REQ-001 SHALL provide parameter SPRINKLE_TICKS, default 60: sprinkler-only run length in tick pulses (30 s ticks, 30 min).
REQ-002 SHALL provide parameter DRIP_TICKS, default 120: drip run length in tick pulses, used both for drip-only runs and for the drip phase of sprinkler-drip runs.
REQ-003 SHALL provide parameter SD_SPRINKLE_TICKS, default 45: sprinkler phase of a sprinkler-drip run (22:30 min).
REQ-004 SHALL provide parameter PRIME_TICKS, default 2: pump prime length, used only when IRRIG_PUMP_PRESTART_EN is defined.
REQ-005 SHALL size every counter at 8 bits; every parameter SHALL be in the range 1..255.
REQ-006 clk  input  1  single system clock, rising edge.
REQ-007 init  input  1  synchronous, active-low reset.
REQ-008 type_of_irrigation_state  input  3  irrigation command: 001 sprinkler-drip, 010 drip, 100 sprinkler, 000 none.
REQ-009 water_ok  input  1  reservoir level sufficient.
REQ-010 tick  input  1  one-clk strobe every 30 s.
REQ-011 sprinkler_valve  output  1  sprinkler solenoid.
REQ-012 drip_valve  output  1  drip solenoid.
REQ-013 pump  output  1  pump motor.
REQ-014 busy  output  1  high in any state other than IDLE, DONE or FAULT.
REQ-015 fault  output  1  high in FAULT.

Function
REQ-016 FSM states SHALL be IDLE, PRIME, SPRINKLE, SD_SPRINKLE, SD_DRIP, DRIP, DONE and FAULT; all outputs SHALL be registered and change on the clk edge that enters the new state.
REQ-017 In IDLE, with water_ok=1, a command of 100, 010 or 001 SHALL go to SPRINKLE, DRIP or SD_SPRINKLE respectively (via PRIME if the macro is defined); command 000 SHALL remain in IDLE.
REQ-018 In IDLE, any command with more than one bit set, or water_ok=0 together with a nonzero command, SHALL go to FAULT.
REQ-019 Each timed state SHALL clear its counter on entry, increment it on each tick, and exit on the clk edge that samples the Nth tick, where N is the state's parameter.
REQ-020 SPRINKLE SHALL drive sprinkler_valve=1 and pump=1, and on expiry go to DONE.
REQ-021 DRIP SHALL drive drip_valve=1 and pump=1, and on expiry go to DONE.
REQ-022 SD_SPRINKLE SHALL drive sprinkler_valve=1 and pump=1, and on expiry go to SD_DRIP.
REQ-023 SD_DRIP SHALL drive drip_valve=1 and pump=1, and on expiry go to DONE.
REQ-024 Sprinkler_valve and drip_valve SHALL never be high in the same cycle, and pump SHALL never be high in IDLE, DONE or FAULT.
REQ-025 During any busy state, command 000 (soil wet) SHALL go to IDLE on the next edge with all outputs low.
REQ-026 During any busy state, water_ok=0 SHALL go to FAULT on the next edge; this SHALL take priority over REQ-025.
REQ-027 During any busy state, a change to another nonzero command SHALL be ignored until the run ends.
REQ-028 DONE SHALL hold all actuator outputs low and return to IDLE only when the command is 000, preventing an immediate re-run.
REQ-029 FAULT SHALL hold valves and pump low and return to IDLE when the command is 000 and water_ok=1.
REQ-030 A tick arriving on the same edge as an exit condition (REQ-025/026) SHALL be ignored.

Reset
REQ-031 With init=0 at a clk edge, the state SHALL go to IDLE, counters SHALL clear, and sprinkler_valve, drip_valve, pump, busy and fault SHALL all be 0, including in the middle of a run.
REQ-032 The first command SHALL be evaluated on the first edge with init=1.

Configuration
REQ-033 With IRRIG_PUMP_PRESTART_EN defined, starting any run SHALL enter PRIME: pump=1, valves=0, for PRIME_TICKS ticks, then the run state selected in REQ-017; REQ-025/026 apply in PRIME.
REQ-034 Without IRRIG_PUMP_PRESTART_EN, PRIME SHALL not exist, and pump and valve SHALL rise on the same edge.

Verification (SPRINKLE_TICKS=3, DRIP_TICKS=4, SD_SPRINKLE_TICKS=2, PRIME_TICKS=1)
REQ-035 Command 001, water_ok=1, 6 ticks -> sprinkler_valve for 2 ticks, then drip_valve for 4 ticks, then DONE with busy=0; holds until command 000.
REQ-036 Command 100, then 000 after 1 tick -> all outputs 0 on the next edge; IDLE.
REQ-037 Command 110 in IDLE -> fault=1, pump=0; then command 000 with water_ok=1 -> fault=0.
REQ-038 Command 010, water_ok dropped after 2 ticks -> fault=1 with drip_valve=0 on the next edge.
REQ-039 init=0 for one edge during SD_DRIP -> all outputs 0; after release with command 010 -> a fresh DRIP run of 4 ticks.
REQ-040 With IRRIG_PUMP_PRESTART_EN defined, command 100 -> pump=1 with valves 0 for 1 tick, then sprinkler_valve for 3 ticks.
